// File: rtl/bka_pkg.sv
// Shared types and constants for the Brent-Kung prefix adder.
// gp_t carries one generate/propagate pair through the prefix network.
package bka_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int LOG2W         = $clog2(DEFAULT_WIDTH);

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

endpackage

// File: rtl/brent_kung_adder_64_if.sv
// Operand/result bundle for the Brent-Kung adder.
// The master drives operands; the slave (adder) returns live and registered results.
interface brent_kung_adder_64_if
  import bka_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  modport master (
    output a, b, cin,
    input  s, cout, s_q, cout_q
  );

  modport slave (
    input  a, b, cin,
    output s, cout, s_q, cout_q
  );

endinterface

// File: rtl/bk_prefix_cell.sv
// Black cell of the prefix network.
// Merges a high group (gp_hi) with the adjacent lower group (gp_lo).
module bk_prefix_cell
  import bka_pkg::*;
(
  input  gp_t gp_hi,
  input  gp_t gp_lo,
  output gp_t gp_out
);

  assign gp_out = {gp_hi.g | (gp_hi.p & gp_lo.g), gp_hi.p & gp_lo.p};

endmodule

// File: rtl/brent_kung_adder_64.sv
// Brent-Kung parallel-prefix adder: combinational {cout, s} = a + b + cin,
// plus a one-cycle registered copy of the result with synchronous reset.
module brent_kung_adder_64
  import bka_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  brent_kung_adder_64_if.slave bus
);

  localparam int LW     = $clog2(WIDTH);
  localparam int LAST   = 2 * LW - 1;

  // tree[0] holds per-bit pairs, tree[1..LW] the up-sweep, tree[LW+1..LAST] the down-sweep
  gp_t tree [0:LAST][WIDTH];

  logic [WIDTH-1:0] p_bit;
  logic [WIDTH:0]   carry;

  genvar i, k, d;

  generate
    for (i = 0; i < WIDTH; i++) begin : g_bits
      assign p_bit[i] = bus.a[i] ^ bus.b[i];
      // Carry-in enters as the generate of position -1, merged into bit 0
      if (i == 0) begin : g_bit0
        assign tree[0][i] = {(bus.a[0] & bus.b[0]) | (p_bit[0] & bus.cin), p_bit[0]};
      end else begin : g_bitn
        assign tree[0][i] = {bus.a[i] & bus.b[i], p_bit[i]};
      end
    end

    for (k = 1; k <= LW; k++) begin : g_up
      for (i = 0; i < WIDTH; i++) begin : g_col
        if (((i + 1) % (1 << k)) == 0) begin : g_cell
          bk_prefix_cell u_cell (
            .gp_hi  (tree[k-1][i]),
            .gp_lo  (tree[k-1][i - (1 << (k-1))]),
            .gp_out (tree[k][i])
          );
        end else begin : g_pass
          assign tree[k][i] = tree[k-1][i];
        end
      end
    end

    // Down-sweep spans shrink from WIDTH/4 to 1, completing the odd prefix slots
    for (d = 1; d < LW; d++) begin : g_down
      for (i = 0; i < WIDTH; i++) begin : g_col
        if ((i >= (1 << (LW - d))) &&
            (((i + 1) % (1 << (LW - d))) == (1 << (LW - d - 1)))) begin : g_cell
          bk_prefix_cell u_cell (
            .gp_hi  (tree[LW+d-1][i]),
            .gp_lo  (tree[LW+d-1][i - (1 << (LW - d - 1))]),
            .gp_out (tree[LW+d][i])
          );
        end else begin : g_pass
          assign tree[LW+d][i] = tree[LW+d-1][i];
        end
      end
    end

    assign carry[0] = bus.cin;
    for (i = 0; i < WIDTH; i++) begin : g_carry
      assign carry[i+1] = tree[LAST][i].g;
    end
  endgenerate

  assign bus.s    = p_bit ^ carry[WIDTH-1:0];
  assign bus.cout = carry[WIDTH];

  // Registered copy for pipelined consumers; reset clears only this stage
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s_q    <= '0;
      bus.cout_q <= 1'b0;
    end else begin
      bus.s_q    <= bus.s;
      bus.cout_q <= bus.cout;
    end
  end

endmodule

// File: tb/tb_brent_kung_adder_64.sv
// Self-checking bench: 64-bit and 16-bit adders compared every cycle against
// plain-arithmetic models, with literal vectors pinning the model.
module tb_brent_kung_adder_64;
  import bka_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  brent_kung_adder_64_if #(.WIDTH(64)) bus64 ();
  brent_kung_adder_64_if #(.WIDTH(16)) bus16 ();

  brent_kung_adder_64 #(.WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus64.slave)
  );

  brent_kung_adder_64 #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  int checks = 0;
  int passes = 0;

  logic [64:0] exp_q64;
  logic [16:0] exp_q16;
  bit          q_valid = 1'b0;

  function automatic logic [64:0] model64(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin);
    return {1'b0, a} + {1'b0, b} + {64'd0, cin};
  endfunction

  function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                input logic [15:0] a16, input logic [15:0] b16,
                                input logic cin16);
    @(posedge clk);
    #1;
    bus64.a   = a;
    bus64.b   = b;
    bus64.cin = cin;
    bus16.a   = a16;
    bus16.b   = b16;
    bus16.cin = cin16;
  endtask

  // Literal expectation for the 64-bit adder: model, live outputs, then registered outputs
  task automatic check_output(input string name, input logic [64:0] exp);
    check({name, "_model"}, model64(bus64.a, bus64.b, bus64.cin), exp);
    @(negedge clk);
    check({name, "_comb"}, {bus64.cout, bus64.s}, exp);
    @(posedge clk);
    #1;
    check({name, "_reg"}, {bus64.cout_q, bus64.s_q}, exp);
  endtask

  // Expected registered values follow what the DUT registers see at each rising edge
  always @(posedge clk) begin
    if (rst) begin
      exp_q64 <= '0;
      exp_q16 <= '0;
      q_valid <= 1'b1;
    end else begin
      exp_q64 <= model64(bus64.a, bus64.b, bus64.cin);
      exp_q16 <= model16(bus16.a, bus16.b, bus16.cin);
    end
  end

  always @(negedge clk) begin
    check("comb64", {bus64.cout, bus64.s}, model64(bus64.a, bus64.b, bus64.cin));
    check("comb16", {48'd0, bus16.cout, bus16.s}, {48'd0, model16(bus16.a, bus16.b, bus16.cin)});
    if (q_valid) begin
      check("reg64", {bus64.cout_q, bus64.s_q}, exp_q64);
      check("reg16", {48'd0, bus16.cout_q, bus16.s_q}, {48'd0, exp_q16});
    end
  end

  logic [15:0] corners [7];

  initial begin
    rst       = 1'b1;
    bus64.a   = '0;
    bus64.b   = '0;
    bus64.cin = 1'b0;
    bus16.a   = '0;
    bus16.b   = '0;
    bus16.cin = 1'b0;
    corners   = '{16'h0000, 16'hffff, 16'h5555, 16'haaaa, 16'h8000, 16'h7fff, 16'h0001};

    // Nonzero operands under reset: live sum visible, registered copy held at zero
    apply_stimulus(64'hb1251b14db93efe6, 64'h3b1c452da1aefadc, 1'b1, 16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    check("rst_comb", {bus64.cout, bus64.s}, {1'b0, 64'hec4160427d42eac3});
    check("rst_reg_cyc1", {bus64.cout_q, bus64.s_q}, 65'd0);
    @(posedge clk);
    #1;
    check("rst_reg_cyc2", {bus64.cout_q, bus64.s_q}, 65'd0);
    check("rst_comb_cyc2", {bus64.cout, bus64.s}, {1'b0, 64'hec4160427d42eac3});
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_reg", {bus64.cout_q, bus64.s_q}, {1'b0, 64'hec4160427d42eac3});

    apply_stimulus(64'hc06bb37b75ffdfe4, 64'h85036b62ba333a12, 1'b0, 16'hffff, 16'h0000, 1'b1);
    check_output("vec2", {1'b1, 64'h456f1ede303319f6});
    apply_stimulus(64'hf73a4ac5621cea98, 64'h242b92d441105cc4, 1'b1, 16'h5555, 16'haaaa, 1'b0);
    check_output("vec3", {1'b1, 64'h1b65dd99a32d475d});
    apply_stimulus(64'hffffffffffffffff, 64'h0, 1'b1, 16'hffff, 16'hffff, 1'b1);
    check_output("wrap", {1'b1, 64'h0});
    apply_stimulus(64'h5555555555555555, 64'haaaaaaaaaaaaaaaa, 1'b0, 16'h0, 16'h0, 1'b0);
    check_output("alt", {1'b0, 64'hffffffffffffffff});
    apply_stimulus(64'h0, 64'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    check_output("zero", 65'd0);
    apply_stimulus(64'h5555555555555555, 64'haaaaaaaaaaaaaaaa, 1'b1, 16'h0, 16'h0, 1'b0);
    check_output("alt_cin", {1'b1, 64'h0});

    // 16-bit corner sweep; the 64-bit side rides along with random operands
    foreach (corners[x]) begin
      foreach (corners[y]) begin
        for (int c = 0; c < 2; c++) begin
          apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, c[0],
                         corners[x], corners[y], c[0]);
        end
      end
    end

    for (int n = 0; n < 20000; n++) begin
      apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                     16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 63) == 0);
    end

    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
